// File: rtl/calendar_pkg.sv
// Shared types, constants and BCD calendar helpers for the calendar_gen date counter.
package calendar_pkg;

    localparam int DAY   = 0;
    localparam int MONTH = 1;
    localparam int YEAR  = 2;

    localparam logic [7:0] BCD2_ZERO = 8'h00;
    localparam logic [7:0] BCD2_MAX  = 8'h99;
    localparam logic [7:0] MONTH_MIN = 8'h01;
    localparam logic [7:0] MONTH_MAX = 8'h12;
    localparam logic [7:0] DAY_MIN   = 8'h01;

    // Two-digit BCD value divisible by 4, decided on the digits alone.
    function automatic logic bcd_div4(input logic [7:0] v);
        logic r;
        if (v[4] == 1'b0) begin
            r = (v[3:0] == 4'h0) || (v[3:0] == 4'h4) || (v[3:0] == 4'h8);
        end else begin
            r = (v[3:0] == 4'h2) || (v[3:0] == 4'h6);
        end
        return r;
    endfunction

    function automatic logic bcd_leap(input logic [7:0] yy, input logic [7:0] century);
        return (yy == 8'h00) ? bcd_div4(century) : bcd_div4(yy);
    endfunction

    function automatic logic [7:0] month_len(input logic [7:0] month_bcd, input logic leap);
        logic [7:0] r;
        case (month_bcd)
            8'h01, 8'h03, 8'h05, 8'h07, 8'h08, 8'h10, 8'h12: r = 8'h31;
            8'h04, 8'h06, 8'h09, 8'h11:                       r = 8'h30;
            8'h02:                                            r = leap ? 8'h29 : 8'h28;
            default:                                          r = 8'h31;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'h9) begin
            r = {v[7:4] + 4'h1, 4'h0};
        end else begin
            r = {v[7:4], v[3:0] + 4'h1};
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'h0) begin
            r = {v[7:4] - 4'h1, 4'h9};
        end else begin
            r = {v[7:4], v[3:0] - 4'h1};
        end
        return r;
    endfunction

endpackage

// File: rtl/calendar_gen_bcd2_counter.sv
// Two-digit BCD up/down counter: wraps between MIN_BCD and a runtime max, with an
// optional same-cycle preset that the inc/dec step is then applied to.
module bcd2_counter
    import calendar_pkg::*;
#(
    parameter logic [7:0] MIN_BCD = 8'h00,
    parameter logic [7:0] RST_BCD = 8'h00
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       set,
    input  logic [7:0] set_val,
    input  logic       inc,
    input  logic       dec,
    input  logic [7:0] max_bcd,
    output logic [7:0] q,
    output logic [7:0] nxt,
    output logic       wrap
);

    logic [7:0] q_r;
    logic [7:0] cur_s;
    logic [7:0] nxt_s;
    logic       wrap_s;

    // Next value: preset first, then one wrapping step; inc with dec cancels.
    always_comb begin
        cur_s  = set ? set_val : q_r;
        nxt_s  = cur_s;
        wrap_s = 1'b0;
        if (inc && !dec) begin
            if (cur_s >= max_bcd) begin
                nxt_s  = MIN_BCD;
                wrap_s = 1'b1;
            end else begin
                nxt_s  = bcd_inc(cur_s);
                wrap_s = 1'b0;
            end
        end else if (dec && !inc) begin
            if (cur_s <= MIN_BCD) begin
                nxt_s  = max_bcd;
                wrap_s = 1'b1;
            end else begin
                nxt_s  = bcd_dec(cur_s);
                wrap_s = 1'b0;
            end
        end else begin
            nxt_s  = cur_s;
            wrap_s = 1'b0;
        end
    end

    // Counter state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            q_r <= RST_BCD;
        end else begin
            q_r <= nxt_s;
        end
    end

    assign q    = q_r;
    assign nxt  = nxt_s;
    assign wrap = wrap_s;

endmodule

// File: rtl/calendar_gen.sv
// BCD day/month/year counter for the clock display path. Define WEEKDAY_EN to add a
// loadable weekday register and the load_weekday port.
module calendar_gen
    import calendar_pkg::*;
#(
    parameter int          YEAR_DIGITS  = 4,
    parameter int          BASE_CENTURY = 20,
    parameter logic [31:0] RESET_DATE   = {16'h2025, 8'h01, 8'h01}
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        day_tick,
    input  logic [2:0]                  cnt_inc,
    input  logic [2:0]                  cnt_dec,
    input  logic                        load,
    input  logic [4*YEAR_DIGITS+15:0]   load_data,
`ifdef WEEKDAY_EN
    input  logic [2:0]                  load_weekday,
`endif
    output logic [4*YEAR_DIGITS+15:0]   date_bcd,
    output logic                        leap,
    output logic                        year_carry,
    output logic                        load_err,
    output logic [2:0]                  weekday
);

    localparam int         W            = 4*YEAR_DIGITS + 16;
    localparam logic [7:0] BASE_CEN_BCD = {4'(BASE_CENTURY / 10), 4'(BASE_CENTURY % 10)};

    logic [7:0] dy_q_s, dy_nxt_s, mo_q_s, mo_nxt_s, yl_q_s, yl_nxt_s;
    logic [7:0] cen_q_s, cen_nxt_s, ld_cen_s, cur_len_s, new_len_s, dy_set_val_s;
    logic [7:0] ld_day_s, ld_mon_s, ld_yl_s;
    logic [2:0] e_inc_s, e_dec_s;
    logic       dy_wrap_s, mo_wrap_s, yl_wrap_s, yh_wrap_s;
    logic       ld_ok_s, do_load_s, tick_s, man_s, roll_s;
    logic       mo_inc_s, mo_dec_s, yl_inc_s, yl_dec_s;
    logic       dy_set_s, dy_inc_s, dy_dec_s, yc_s;
    logic       yc_r, le_r;
    logic       dy_unused_s;

    assign ld_day_s  = load_data[7:0];
    assign ld_mon_s  = load_data[15:8];
    assign ld_yl_s   = load_data[23:16];

    assign e_inc_s   = cnt_inc & ~cnt_dec;
    assign e_dec_s   = cnt_dec & ~cnt_inc;
    assign do_load_s = load & ld_ok_s;
    assign tick_s    = ~load & day_tick;
    assign man_s     = ~load & ~day_tick;

    assign leap      = bcd_leap(yl_q_s, cen_q_s);
    assign cur_len_s = month_len(mo_q_s, leap);
    assign roll_s    = (dy_q_s >= cur_len_s);
    // Day limits follow the month/year as they will be after this cycle's edits.
    assign new_len_s = month_len(mo_nxt_s, bcd_leap(yl_nxt_s, cen_nxt_s));

    // Load validation: BCD digits, month range, day within that month.
    always_comb begin
        ld_ok_s = 1'b1;
        for (int i = 0; i < W / 4; i++) begin
            ld_ok_s = ld_ok_s & (load_data[4*i +: 4] <= 4'h9);
        end
        ld_ok_s = ld_ok_s & (ld_mon_s >= MONTH_MIN) & (ld_mon_s <= MONTH_MAX)
                & (ld_day_s >= DAY_MIN)
                & (ld_day_s <= month_len(ld_mon_s, bcd_leap(ld_yl_s, ld_cen_s)));
`ifdef WEEKDAY_EN
        ld_ok_s = ld_ok_s & (load_weekday <= 3'd6);
`endif
    end

    assign mo_inc_s = (tick_s & roll_s) | (man_s & e_inc_s[MONTH]);
    assign mo_dec_s = man_s & e_dec_s[MONTH];
    assign yl_inc_s = (tick_s & mo_wrap_s) | (man_s & e_inc_s[YEAR]);
    assign yl_dec_s = man_s & e_dec_s[YEAR];
    assign yc_s     = yl_inc_s & yl_wrap_s & yh_wrap_s;

    // Day control: load, tick rollover/advance, or clamp followed by the manual edit.
    always_comb begin
        dy_set_s     = 1'b0;
        dy_set_val_s = dy_q_s;
        dy_inc_s     = 1'b0;
        dy_dec_s     = 1'b0;
        if (do_load_s) begin
            dy_set_s     = 1'b1;
            dy_set_val_s = ld_day_s;
        end else if (tick_s) begin
            dy_set_s     = roll_s;
            dy_set_val_s = DAY_MIN;
            dy_inc_s     = ~roll_s;
        end else if (man_s) begin
            dy_set_s     = (dy_q_s > new_len_s);
            dy_set_val_s = new_len_s;
            dy_inc_s     = e_inc_s[DAY];
            dy_dec_s     = e_dec_s[DAY];
        end else begin
            dy_set_s     = 1'b0;
        end
    end

    bcd2_counter #(.MIN_BCD(DAY_MIN), .RST_BCD(RESET_DATE[7:0])) u_day (
        .Clk(Clk), .Reset_n(Reset_n), .set(dy_set_s), .set_val(dy_set_val_s),
        .inc(dy_inc_s), .dec(dy_dec_s), .max_bcd(new_len_s),
        .q(dy_q_s), .nxt(dy_nxt_s), .wrap(dy_wrap_s)
    );

    bcd2_counter #(.MIN_BCD(MONTH_MIN), .RST_BCD(RESET_DATE[15:8])) u_month (
        .Clk(Clk), .Reset_n(Reset_n), .set(do_load_s), .set_val(ld_mon_s),
        .inc(mo_inc_s), .dec(mo_dec_s), .max_bcd(MONTH_MAX),
        .q(mo_q_s), .nxt(mo_nxt_s), .wrap(mo_wrap_s)
    );

    bcd2_counter #(.MIN_BCD(BCD2_ZERO), .RST_BCD(RESET_DATE[23:16])) u_year_lo (
        .Clk(Clk), .Reset_n(Reset_n), .set(do_load_s), .set_val(ld_yl_s),
        .inc(yl_inc_s), .dec(yl_dec_s), .max_bcd(BCD2_MAX),
        .q(yl_q_s), .nxt(yl_nxt_s), .wrap(yl_wrap_s)
    );

    assign dy_unused_s = ^{dy_nxt_s, dy_wrap_s};

    generate
        if (YEAR_DIGITS == 4) begin : g_year_hi
            bcd2_counter #(.MIN_BCD(BCD2_ZERO), .RST_BCD(RESET_DATE[31:24])) u_year_hi (
                .Clk(Clk), .Reset_n(Reset_n), .set(do_load_s), .set_val(load_data[W-1 -: 8]),
                .inc(yl_wrap_s & yl_inc_s), .dec(yl_wrap_s & yl_dec_s), .max_bcd(BCD2_MAX),
                .q(cen_q_s), .nxt(cen_nxt_s), .wrap(yh_wrap_s)
            );
            assign ld_cen_s = load_data[W-1 -: 8];
            assign date_bcd = {cen_q_s, yl_q_s, mo_q_s, dy_q_s};
        end else begin : g_year_2d
            assign cen_q_s   = BASE_CEN_BCD;
            assign cen_nxt_s = BASE_CEN_BCD;
            assign ld_cen_s  = BASE_CEN_BCD;
            assign yh_wrap_s = 1'b1;
            assign date_bcd  = {yl_q_s, mo_q_s, dy_q_s};
        end
    endgenerate

    // One-cycle year wrap and load rejection pulses.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            yc_r <= 1'b0;
            le_r <= 1'b0;
        end else begin
            yc_r <= yc_s;
            le_r <= load & ~ld_ok_s;
        end
    end

    assign year_carry = yc_r;
    assign load_err   = le_r;

`ifdef WEEKDAY_EN
    logic [2:0] wd_r;

    // Weekday follows day steps only; month/year edits leave it alone.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wd_r <= 3'd0;
        end else if (do_load_s) begin
            wd_r <= load_weekday;
        end else if (tick_s || (man_s && e_inc_s[DAY])) begin
            wd_r <= (wd_r == 3'd6) ? 3'd0 : wd_r + 3'd1;
        end else if (man_s && e_dec_s[DAY]) begin
            wd_r <= (wd_r == 3'd0) ? 3'd6 : wd_r - 3'd1;
        end else begin
            wd_r <= wd_r;
        end
    end

    assign weekday = wd_r;
`else
    assign weekday = 3'd0;
`endif

endmodule

// File: tb/tb_calendar_gen.sv
// Self-checking bench for calendar_gen: directed steps plus random traffic against
// an integer date model; a second instance covers the 2-digit-year build.
module tb_calendar_gen;

    localparam logic [31:0] RST_DATE = 32'h20250101;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        day_tick, load;
    logic [2:0]  cnt_inc, cnt_dec;
    logic [31:0] load_data;
    logic [31:0] date_bcd;
    logic        leap, year_carry, load_err;
    logic [2:0]  weekday;
`ifdef WEEKDAY_EN
    logic [2:0]  load_weekday;
`endif

    logic        load2, tick2;
    logic [2:0]  inc2, dec2;
    logic [23:0] ld2_data, date2;
    logic        leap2, yc2, le2;
    logic [2:0]  wd2;
`ifdef WEEKDAY_EN
    logic [2:0]  lw2;
`endif

    int checks = 0;
    int errors = 0;
    int my, mm, md, mwd;

    always #5 Clk = ~Clk;

    calendar_gen dut (
        .Clk(Clk), .Reset_n(Reset_n), .day_tick(day_tick), .cnt_inc(cnt_inc), .cnt_dec(cnt_dec),
        .load(load), .load_data(load_data),
`ifdef WEEKDAY_EN
        .load_weekday(load_weekday),
`endif
        .date_bcd(date_bcd), .leap(leap), .year_carry(year_carry), .load_err(load_err),
        .weekday(weekday)
    );

    calendar_gen #(.YEAR_DIGITS(2), .BASE_CENTURY(21)) dut2 (
        .Clk(Clk), .Reset_n(Reset_n), .day_tick(tick2), .cnt_inc(inc2), .cnt_dec(dec2),
        .load(load2), .load_data(ld2_data),
`ifdef WEEKDAY_EN
        .load_weekday(lw2),
`endif
        .date_bcd(date2), .leap(leap2), .year_carry(yc2), .load_err(le2),
        .weekday(wd2)
    );

    function automatic bit is_leap(input int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    function automatic int mlen(input int y, input int m);
        case (m)
            2:           return is_leap(y) ? 29 : 28;
            4, 6, 9, 11: return 30;
            default:     return 31;
        endcase
    endfunction

    function automatic logic [31:0] to_bcd_date(input int y, input int m, input int d);
        logic [31:0] r;
        r = {4'(y / 1000), 4'((y / 100) % 10), 4'((y / 10) % 10), 4'(y % 10),
             4'(m / 10), 4'(m % 10), 4'(d / 10), 4'(d % 10)};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: the date rules applied to plain integers.
    task automatic model(input bit ld, input logic [31:0] dat, input bit tk,
                         input logic [2:0] ci, input logic [2:0] cd, input logic [2:0] lw,
                         output bit ec, output bit ee);
        bit ok;
        int y, m, d, len;
        logic [2:0] ei, ed;
        ec = 1'b0;
        ee = 1'b0;
        if (ld) begin
            ok = 1'b1;
            for (int i = 0; i < 8; i++) if (dat[4*i +: 4] > 4'd9) ok = 1'b0;
            y = int'(dat[31:28]) * 1000 + int'(dat[27:24]) * 100 + int'(dat[23:20]) * 10 + int'(dat[19:16]);
            m = int'(dat[15:12]) * 10 + int'(dat[11:8]);
            d = int'(dat[7:4]) * 10 + int'(dat[3:0]);
            if (m < 1 || m > 12) ok = 1'b0;
            else if (d < 1 || d > mlen(y, m)) ok = 1'b0;
`ifdef WEEKDAY_EN
            if (lw > 3'd6) ok = 1'b0;
`endif
            if (ok) begin
                my = y; mm = m; md = d; mwd = int'(lw);
            end else begin
                ee = 1'b1;
            end
        end else if (tk) begin
            mwd = (mwd + 1) % 7;
            if (md < mlen(my, mm)) md++;
            else begin
                md = 1;
                if (mm == 12) begin
                    mm = 1;
                    if (my == 9999) begin my = 0; ec = 1'b1; end
                    else my++;
                end else mm++;
            end
        end else begin
            ei = ci & ~cd;
            ed = cd & ~ci;
            if (ei[2]) begin
                if (my == 9999) begin my = 0; ec = 1'b1; end
                else my++;
            end else if (ed[2]) my = (my == 0) ? 9999 : my - 1;
            if (ei[1]) mm = (mm == 12) ? 1 : mm + 1;
            else if (ed[1]) mm = (mm == 1) ? 12 : mm - 1;
            len = mlen(my, mm);
            if (md > len) md = len;
            if (ei[0]) begin
                md = (md == len) ? 1 : md + 1;
                mwd = (mwd + 1) % 7;
            end else if (ed[0]) begin
                md = (md == 1) ? len : md - 1;
                mwd = (mwd + 6) % 7;
            end
        end
    endtask

    task automatic step(input bit ld, input logic [31:0] dat, input bit tk,
                        input logic [2:0] ci, input logic [2:0] cd, input logic [2:0] lw,
                        input string tag);
        bit ec, ee;
        load = ld; load_data = dat; day_tick = tk; cnt_inc = ci; cnt_dec = cd;
`ifdef WEEKDAY_EN
        load_weekday = lw;
`endif
        model(ld, dat, tk, ci, cd, lw, ec, ee);
        @(posedge Clk);
        #1;
        load = 1'b0; day_tick = 1'b0; cnt_inc = 3'd0; cnt_dec = 3'd0;
        chk({tag, " date"}, date_bcd, to_bcd_date(my, mm, md));
        chk({tag, " year_carry"}, 32'(year_carry), 32'(ec));
        chk({tag, " load_err"}, 32'(load_err), 32'(ee));
        chk({tag, " leap"}, 32'(leap), 32'(is_leap(my)));
`ifdef WEEKDAY_EN
        chk({tag, " weekday"}, 32'(weekday), 32'(mwd));
`else
        chk({tag, " weekday"}, 32'(weekday), 32'd0);
`endif
    endtask

    task automatic step2(input bit ld, input logic [23:0] dat, input bit tk);
        load2 = ld; ld2_data = dat; tick2 = tk;
        @(posedge Clk);
        #1;
        load2 = 1'b0; tick2 = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        bit          rl, rt;
        logic [2:0]  ri, rdc;
        Reset_n = 1'b1; day_tick = 1'b0; load = 1'b0; cnt_inc = 3'd0; cnt_dec = 3'd0;
        load_data = 32'd0; load2 = 1'b0; tick2 = 1'b0; inc2 = 3'd0; dec2 = 3'd0; ld2_data = 24'd0;
`ifdef WEEKDAY_EN
        load_weekday = 3'd0; lw2 = 3'd0;
`endif
        my = 2025; mm = 1; md = 1; mwd = 0;
        #1 Reset_n = 1'b0;
        #6;
        chk("reset date", date_bcd, RST_DATE);
        chk("reset year_carry", 32'(year_carry), 32'd0);
        chk("reset load_err", 32'(load_err), 32'd0);
        chk("reset weekday", 32'(weekday), 32'd0);
        chk("reset date yd2", 32'(date2), 32'h00250101 & 32'h00FFFFFF);
        #5 Reset_n = 1'b1;

        for (int i = 0; i < 31; i++) step(1'b0, 32'd0, 1'b1, 3'd0, 3'd0, 3'd0, "tick jan");
        chk("31 ticks", date_bcd, 32'h20250201);
        for (int i = 0; i < 28; i++) step(1'b0, 32'd0, 1'b1, 3'd0, 3'd0, 3'd0, "tick feb");
        chk("59 ticks", date_bcd, 32'h20250301);

        step(1'b1, 32'h20000228, 1'b0, 3'd0, 3'd0, 3'd0, "load 2000");
        step(1'b0, 32'd0, 1'b1, 3'd0, 3'd0, 3'd0, "tick 2000");
        chk("leap 2000", date_bcd, 32'h20000229);
        step(1'b1, 32'h19000228, 1'b0, 3'd0, 3'd0, 3'd0, "load 1900");
        step(1'b0, 32'd0, 1'b1, 3'd0, 3'd0, 3'd0, "tick 1900");
        chk("noleap 1900", date_bcd, 32'h19000301);
        step(1'b1, 32'h20240228, 1'b0, 3'd0, 3'd0, 3'd0, "load 2024");
        step(1'b0, 32'd0, 1'b1, 3'd0, 3'd0, 3'd0, "tick 2024");
        chk("leap 2024", date_bcd, 32'h20240229);

        step(1'b1, 32'h99991231, 1'b0, 3'd0, 3'd0, 3'd0, "load 9999");
        step(1'b0, 32'd0, 1'b1, 3'd0, 3'd0, 3'd0, "tick wrap");
        chk("wrap date", date_bcd, 32'h00000101);
        chk("wrap carry", 32'(year_carry), 32'd1);
        step(1'b0, 32'd0, 1'b0, 3'd0, 3'd0, 3'd0, "after wrap");
        step(1'b1, 32'h00000505, 1'b0, 3'd0, 3'd0, 3'd0, "load 0000");
        step(1'b0, 32'd0, 1'b0, 3'd0, 3'b100, 3'd0, "year dec");
        chk("year dec wrap", date_bcd, 32'h99990505);

        step(1'b1, 32'h20230131, 1'b0, 3'd0, 3'd0, 3'd0, "load jan31");
        step(1'b0, 32'd0, 1'b0, 3'b010, 3'd0, 3'd0, "month inc");
        chk("clamp feb", date_bcd, 32'h20230228);
        step(1'b0, 32'd0, 1'b0, 3'b001, 3'd0, 3'd0, "day inc");
        chk("day wrap", date_bcd, 32'h20230201);
        step(1'b0, 32'd0, 1'b0, 3'b001, 3'b001, 3'd0, "inc dec");
        chk("inc dec cancel", date_bcd, 32'h20230201);

        step(1'b1, 32'h20230229, 1'b0, 3'd0, 3'd0, 3'd0, "bad feb29");
        step(1'b1, 32'h20231301, 1'b0, 3'd0, 3'd0, 3'd0, "bad month13");
        step(1'b1, 32'h20230A01, 1'b0, 3'd0, 3'd0, 3'd0, "bad nibble");
        chk("bad kept", date_bcd, 32'h20230201);
        step(1'b0, 32'd0, 1'b0, 3'd0, 3'd0, 3'd0, "after bad");

        step(1'b1, 32'h20230615, 1'b1, 3'd0, 3'd0, 3'd0, "load+tick");
        chk("load wins", date_bcd, 32'h20230615);

        step(1'b1, 32'h20250105, 1'b0, 3'd0, 3'd0, 3'd6, "load wd6");
        step(1'b0, 32'd0, 1'b1, 3'd0, 3'd0, 3'd0, "wd tick");
        step(1'b0, 32'd0, 1'b0, 3'd0, 3'b001, 3'd0, "wd dec");
        step(1'b0, 32'd0, 1'b0, 3'b110, 3'd0, 3'd0, "wd month yr");
        step(1'b1, 32'h20250105, 1'b0, 3'd0, 3'd0, 3'd7, "load wd7");

        for (int n = 0; n < 500; n++) begin
            rl = ($urandom_range(0, 9) == 0);
            rt = ($urandom_range(0, 2) == 0);
            ri = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            rdc = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            case ($urandom_range(0, 3))
                0:       rd = $urandom;
                1:       rd = to_bcd_date(($urandom_range(0, 1) == 0) ? 9999 : 0,
                                          $urandom_range(1, 12), $urandom_range(1, 31));
                default: rd = to_bcd_date($urandom_range(0, 9999), $urandom_range(1, 12),
                                          $urandom_range(1, 31));
            endcase
            step(rl, rd, rt, ri, rdc, 3'($urandom_range(0, 7)), "random");
        end

        step(1'b1, 32'h20231301, 1'b0, 3'd0, 3'd0, 3'd0, "bad pre-reset");
        day_tick = 1'b1;
        Reset_n = 1'b0;
        #1;
        chk("midreset date", date_bcd, RST_DATE);
        chk("midreset load_err", 32'(load_err), 32'd0);
        chk("midreset weekday", 32'(weekday), 32'd0);
        #2;
        Reset_n = 1'b1;
        day_tick = 1'b0;
        my = 2025; mm = 1; md = 1; mwd = 0;
        step(1'b0, 32'd0, 1'b0, 3'd0, 3'd0, 3'd0, "post reset");

        step2(1'b1, 24'h000228, 1'b0);
        step2(1'b0, 24'h000000, 1'b1);
        chk("yd2 2100 noleap", 32'(date2), 32'h00000301);
        chk("yd2 leap flag", 32'(leap2), 32'd0);
        step2(1'b1, 24'h040228, 1'b0);
        step2(1'b0, 24'h000000, 1'b1);
        chk("yd2 2104 leap", 32'(date2), 32'h00040229);
        step2(1'b1, 24'h991231, 1'b0);
        step2(1'b0, 24'h000000, 1'b1);
        chk("yd2 wrap", 32'(date2), 32'h00000101);
        chk("yd2 carry", 32'(yc2), 32'd1);
        chk("yd2 load_err", 32'(le2), 32'd0);
        step2(1'b1, 24'h990229, 1'b0);
        chk("yd2 bad load", 32'(le2), 32'd1);
        chk("yd2 bad kept", 32'(date2), 32'h00000101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
